// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator scheduler and car datapath.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam int DEF_NUM_FLOORS = 16;
  localparam int DEF_FLOOR_W    = 4;

endpackage

// File: rtl/floor_prio_enc.sv
// Nearest-pending-floor search: lowest set bit above pos when search_up,
// otherwise highest set bit below pos.
module floor_prio_enc
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]    pos,
  input  logic                  search_up,
  output logic                  found,
  output logic [FLOOR_W-1:0]    index
);

  logic [NUM_FLOORS-1:0] cand;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
    assign cand[gi] = req[gi] &&
                      (search_up ? (FLOOR_W'(gi) > pos) : (FLOOR_W'(gi) < pos));
  end

  // Scan order is chosen so the last hit is the floor nearest to pos.
  always_comb begin
    found = |cand;
    index = '0;
    if (search_up) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (cand[i]) index = FLOOR_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (cand[i]) index = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-policy request scheduler: latches floor calls, steers the car toward the
// nearest pending floor in the sweep direction and times the door.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    car_floor,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  busy,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_floor_q, target_floor_d;
  logic                  dir_up_q, dir_up_d;
  logic                  door_open_q, door_open_d;
  logic [CNT_W-1:0]      door_cnt_q, door_cnt_d;

  logic [NUM_FLOORS-1:0] above_mask, below_mask, call_hot, tgt_hot, set_hot;
  logic                  any_above, any_below, search_up, call_ok, call_here;
  logic                  enc_found;
  logic [FLOOR_W-1:0]    enc_index;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_side
    assign above_mask[gi] = pending_q[gi] && (FLOOR_W'(gi) > car_floor);
    assign below_mask[gi] = pending_q[gi] && (FLOOR_W'(gi) < car_floor);
  end

  assign any_above = |above_mask;
  assign any_below = |below_mask;
  // While moving the sweep direction is fixed; from IDLE keep going the same
  // way unless nothing lies ahead.
  assign search_up = (state_q == MOVE) ? dir_up_q : (any_above && (dir_up_q || !any_below));
  assign call_ok   = call_valid && (int'(call_floor) < NUM_FLOORS);
  assign call_here = call_ok && (call_floor == car_floor);
  assign call_hot  = NUM_FLOORS'(1) << call_floor;
  assign tgt_hot   = NUM_FLOORS'(1) << target_floor_q;

  floor_prio_enc #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_prio_enc (
    .req      (pending_q),
    .pos      (car_floor),
    .search_up(search_up),
    .found    (enc_found),
    .index    (enc_index)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      target_floor_q <= '0;
      dir_up_q       <= 1'b1;
      door_open_q    <= 1'b0;
      door_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_floor_q <= target_floor_d;
      dir_up_q       <= dir_up_d;
      door_open_q    <= door_open_d;
      door_cnt_q     <= door_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    target_floor_d = target_floor_q;
    dir_up_d       = dir_up_q;
    door_open_d    = door_open_q;
    door_cnt_d     = door_cnt_q;
    set_hot        = call_ok ? call_hot : '0;
    case (state_q)
      IDLE: begin
        if (call_here) begin
          state_d     = DOOR;
          door_open_d = 1'b1;
          door_cnt_d  = CNT_W'(DOOR_CYCLES);
          set_hot     = '0;
        end else if (|pending_q) begin
          state_d        = MOVE;
          dir_up_d       = search_up;
          target_floor_d = enc_found ? enc_index : car_floor;
        end
      end
      MOVE: begin
        if (car_floor == target_floor_q) begin
          // A call for the arriving floor is served by this door opening.
          pending_d   = pending_q & ~tgt_hot;
          state_d     = DOOR;
          door_open_d = 1'b1;
          door_cnt_d  = CNT_W'(DOOR_CYCLES);
          if (call_here) set_hot = '0;
        end else if (enc_found) begin
          target_floor_d = enc_index;
        end
      end
      DOOR: begin
        if (call_here) begin
          door_cnt_d = CNT_W'(DOOR_CYCLES);
          set_hot    = '0;
        end else if (door_cnt_q == CNT_W'(1)) begin
          state_d     = IDLE;
          door_open_d = 1'b0;
          door_cnt_d  = '0;
        end else begin
          door_cnt_d = door_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = pending_d | set_hot;
  end

  always_comb begin
    target_floor = target_floor_q;
    dir_up       = dir_up_q;
    door_open    = door_open_q;
    pending      = pending_q;
    busy         = (state_q != IDLE) || (|pending_q);
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: vector table, directed corner sequences and a
// randomized run against a floor-level behavioural model.
module tb_elevator_scheduler;

  localparam int NF = 16;
  localparam int FW = 5;   // one spare bit so out-of-range calls can be driven
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          call_valid = 1'b0;
  logic [FW-1:0] call_floor = '0;
  logic [FW-1:0] car_floor = '0;
  logic [FW-1:0] target_floor;
  logic          dir_up, door_open, busy;
  logic [NF-1:0] pending;

  elevator_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .call_valid  (call_valid),
    .call_floor  (call_floor),
    .car_floor   (car_floor),
    .target_floor(target_floor),
    .dir_up      (dir_up),
    .door_open   (door_open),
    .busy        (busy),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0=idle, 1=moving, 2=door open.
  int      m_state;
  bit [NF-1:0] m_pend;
  int      m_tgt;
  bit      m_dir, m_door;
  int      m_cnt;
  int      car = 0;

  typedef struct {
    bit cv;
    int cf;
    int car;
    int e_tgt;
    bit e_dir;
    bit e_door;
    bit e_busy;
    int e_pend;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pend = '0; m_tgt = 0; m_dir = 1'b1; m_door = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input bit cv, input int cf, input int c);
    bit ok, here, setb;
    int above, below, t;
    ok = cv && (cf < NF);
    here = ok && (cf == c);
    setb = ok;
    above = -1;
    below = -1;
    for (int f = c + 1; f < NF; f++) if (m_pend[f] && above < 0) above = f;
    for (int f = 0; f < c && f < NF; f++) if (m_pend[f]) below = f;
    case (m_state)
      0: begin
        if (here) begin
          m_state = 2; m_door = 1'b1; m_cnt = DC; setb = 1'b0;
        end else if (m_pend != 0) begin
          m_state = 1;
          if (above >= 0 && (m_dir || below < 0)) begin
            m_dir = 1'b1; m_tgt = above;
          end else begin
            m_dir = 1'b0; m_tgt = (below >= 0) ? below : c;
          end
        end
      end
      1: begin
        if (c == m_tgt) begin
          m_pend[m_tgt] = 1'b0; m_door = 1'b1; m_cnt = DC; m_state = 2;
          if (here) setb = 1'b0;
        end else begin
          t = m_dir ? above : below;
          if (t >= 0) m_tgt = t;
        end
      end
      default: begin
        if (here) begin
          m_cnt = DC; setb = 1'b0;
        end else if (m_cnt == 1) begin
          m_door = 1'b0; m_cnt = 0; m_state = 0;
        end else begin
          m_cnt--;
        end
      end
    endcase
    if (setb) m_pend[cf] = 1'b1;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_tgt"},  int'(target_floor), m_tgt);
    chk({tag, "_dir"},  int'(dir_up), int'(m_dir));
    chk({tag, "_door"}, int'(door_open), int'(m_door));
    chk({tag, "_busy"}, int'(busy), int'(m_state != 0 || m_pend != 0));
    chk({tag, "_pend"}, int'(pending), int'(m_pend));
  endtask

  task automatic cycle(input bit cv, input int cf, input int c, input string tag);
    call_valid = cv;
    call_floor = FW'(cf);
    car_floor  = FW'(c);
    @(posedge clk);
    model_step(cv, cf, c);
    #1;
    compare_model(tag);
    call_valid = 1'b0;
  endtask

  // One cycle with the car stepping toward the model's target while moving.
  task automatic run(input bit cv, input int cf, input string tag);
    cycle(cv, cf, car, tag);
    if (m_state == 1 && car != m_tgt) car += (m_tgt > car) ? 1 : -1;
  endtask

  task automatic do_reset(input bit check);
    call_valid = 1'b0;
    rst = 1'b0;
    #1;
    if (check) begin
      chk("rst_tgt",  int'(target_floor), 0);
      chk("rst_dir",  int'(dir_up), 1);
      chk("rst_door", int'(door_open), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pend", int'(pending), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    model_reset();
    @(posedge clk);
    do_reset(1'b1);

    // Car at 0, single call to 5, travel, door for DC cycles, back to idle.
    for (int i = 0; i < 15; i++) begin
      tbl[i].cv = 1'b0; tbl[i].cf = 0; tbl[i].car = 5;
      tbl[i].e_tgt = 5; tbl[i].e_dir = 1'b1;
      tbl[i].e_door = (i >= 6 && i <= 13);
      tbl[i].e_busy = (i < 14);
      tbl[i].e_pend = (i < 6) ? 32 : 0;
    end
    tbl[0].cv = 1'b1; tbl[0].cf = 5; tbl[0].car = 0; tbl[0].e_tgt = 0;
    tbl[1].car = 0;
    for (int i = 2; i <= 5; i++) tbl[i].car = i - 1;
    for (int i = 0; i < 15; i++) begin
      call_valid = tbl[i].cv;
      call_floor = FW'(tbl[i].cf);
      car_floor  = FW'(tbl[i].car);
      @(posedge clk);
      model_step(tbl[i].cv, tbl[i].cf, tbl[i].car);
      #1;
      chk($sformatf("vec%0d_tgt", i),  int'(target_floor), tbl[i].e_tgt);
      chk($sformatf("vec%0d_dir", i),  int'(dir_up), int'(tbl[i].e_dir));
      chk($sformatf("vec%0d_door", i), int'(door_open), int'(tbl[i].e_door));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_pend", i), int'(pending), tbl[i].e_pend);
    end
    call_valid = 1'b0;

    // Asynchronous reset while moving from 3 toward 7.
    do_reset(1'b0);
    cycle(1'b1, 7, 3, "rm");
    cycle(1'b0, 0, 3, "rm");
    chk("rm_pre_tgt", int'(target_floor), 7);
    rst = 1'b0;
    #1;
    chk("rm_tgt",  int'(target_floor), 0);
    chk("rm_dir",  int'(dir_up), 1);
    chk("rm_door", int'(door_open), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_pend", int'(pending), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Retarget: moving up from 2 toward 9, a call to 4 is picked up first.
    do_reset(1'b0);
    cycle(1'b1, 9, 2, "rt");
    cycle(1'b0, 0, 2, "rt");
    chk("rt_tgt9", int'(target_floor), 9);
    cycle(1'b1, 4, 3, "rt");
    chk("rt_old_tgt", int'(target_floor), 9);
    chk("rt_pend2", int'(pending), 16'h0210);
    cycle(1'b0, 0, 3, "rt");
    chk("rt_tgt4", int'(target_floor), 4);
    cycle(1'b0, 0, 4, "rt");
    chk("rt_door4", int'(door_open), 1);
    chk("rt_pend9", int'(pending), 16'h0200);
    car = 4;
    for (int i = 0; i < 30; i++) begin
      run(1'b0, 0, "rt");
      if (!door_open && target_floor == FW'(9)) break;
    end
    chk("rt_next_tgt", int'(target_floor), 9);
    chk("rt_next_dir", int'(dir_up), 1);
    for (int i = 0; i < 40; i++) begin
      run(1'b0, 0, "rt");
      if (!busy) break;
    end
    chk("rt_drained", int'(busy), 0);

    // LOOK: at 6 going up with {8,2} pending, serve 8 then reverse to 2.
    do_reset(1'b0);
    car = 6;
    cycle(1'b1, 8, 6, "lk");
    cycle(1'b1, 2, 6, "lk");
    chk("lk_first_tgt", int'(target_floor), 8);
    for (int i = 0; i < 40; i++) begin
      run(1'b0, 0, "lk");
      if (!dir_up) break;
    end
    chk("lk_dir",  int'(dir_up), 0);
    chk("lk_tgt",  int'(target_floor), 2);
    chk("lk_pend", int'(pending), 4);

    // Idle at 4, call to 4: straight into DOOR for exactly DC cycles.
    do_reset(1'b0);
    car = 4;
    cycle(1'b1, 4, 4, "dr");
    chk("dr_open", int'(door_open), 1);
    chk("dr_pend", int'(pending), 0);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 0, 4, "dr");
      if (!door_open) break;
      n++;
    end
    chk("dr_len", n, DC);
    chk("dr_idle_busy", int'(busy), 0);

    // Reload when three door cycles remain; out-of-range call is ignored.
    cycle(1'b1, 4, 4, "rl");
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 4, "rl");
    cycle(1'b1, 16, 4, "rl");
    chk("rl_bad_call", int'(pending), 0);
    cycle(1'b1, 4, 4, "rl");
    chk("rl_pend", int'(pending), 0);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 0, 4, "rl");
      if (!door_open) break;
      n++;
    end
    chk("rl_len", n, DC);
    cycle(1'b1, 17, 4, "ib");
    chk("ib_pend", int'(pending), 0);
    chk("ib_busy", int'(busy), 0);

    // Randomized traffic against the model, car following the model's target.
    do_reset(1'b0);
    car = 0;
    for (int i = 0; i < 800; i++) begin
      run(($urandom_range(0, 3) == 0), int'($urandom_range(0, 19)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
